// File: rtl/dsm_decimator.sv
// dsm_decimator: delta-sigma loop latch plus sinc3 decimator producing signed PCM samples
module dsm_decimator #(
  parameter int DEC_LOG2 = 5,
  parameter int OUT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cke,
  input  logic                    dsm_in,
  output logic                    dsm_out,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);
  localparam int W = 3*DEC_LOG2 + 2;
  localparam int SH = 3*DEC_LOG2 + 1 - OUT_W;
  localparam logic signed [W-1:0] Y_MAX = W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [W-1:0] Y_MIN = -Y_MAX - W'(1);
  logic dsm_q, dsm_d;
  logic [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [DEC_LOG2-1:0] ph_q, ph_d;
  logic [1:0] warm_q, warm_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic valid_q, valid_d;
  logic [W-1:0] x, c1, c2, c3;
  logic signed [W-1:0] y;
  logic ev;
  always_comb begin
    x = dsm_q ? W'(1) : '1;
    ev = cke && (ph_q == '1);
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
    y = $signed(c3) >>> SH;
    dsm_d = cke ? dsm_in : dsm_q;
    i1_d = cke ? i1_q + x : i1_q;
    i2_d = cke ? i2_q + i1_q : i2_q;
    i3_d = cke ? i3_q + i2_q : i3_q;
    ph_d = cke ? ph_q + 1'b1 : ph_q;
    d1_d = ev ? i3_q : d1_q;
    d2_d = ev ? c1 : d2_q;
    d3_d = ev ? c2 : d3_q;
    dout_d = !ev ? dout_q : y > Y_MAX ? OUT_W'(Y_MAX) : y < Y_MIN ? OUT_W'(Y_MIN) : OUT_W'(y);
    warm_d = (ev && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
    valid_d = ev && warm_q == 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsm_q <= 1'b0;
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      ph_q <= '0;
      warm_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      dsm_q <= dsm_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
      i3_q <= i3_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      ph_q <= ph_d;
      warm_q <= warm_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
    end
  end
  assign dsm_out = dsm_q;
  assign dout = dout_q;
  assign dout_valid = valid_q;
endmodule

// File: tb/tb_dsm_decimator.sv
// tb_dsm_decimator: randomized self-checking bench against an exact-integer sinc3 reference
module tb_dsm_decimator;
  localparam int DEC_LOG2 = 5;
  localparam int OUT_W = 10;
  localparam int R = 1 << DEC_LOG2;
  localparam int SH = 3*DEC_LOG2 + 1 - OUT_W;
  localparam longint LIM = 1 << (OUT_W-1);
  logic clk = 1'b0;
  logic rst, cke, dsm_in, dsm_out, dout_valid;
  logic signed [OUT_W-1:0] dout;
  int n_cmp = 0;
  int n_err = 0;
  bit m_dsm;
  longint s1, s2, s3, h0, h1, h2, n_cke;
  int m_ph, m_ev;
  bit e_valid;
  logic signed [OUT_W-1:0] e_dout;
  always #5 clk = ~clk;
  dsm_decimator #(.DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .cke(cke), .dsm_in(dsm_in),
    .dsm_out(dsm_out), .dout(dout), .dout_valid(dout_valid)
  );
  task automatic model_reset();
    m_dsm = 0; s1 = 0; s2 = 0; s3 = 0; h0 = 0; h1 = 0; h2 = 0;
    m_ph = 0; m_ev = 0; e_valid = 0; e_dout = '0; n_cke = 0;
  endtask
  task automatic model_cke(input bit din);
    longint c3, y;
    e_valid = 0;
    if (m_ph == R-1) begin
      c3 = s3 - 3*h0 + 3*h1 - h2;
      h2 = h1; h1 = h0; h0 = s3;
      y = c3 >>> SH;
      y = y > LIM-1 ? LIM-1 : (y < -LIM ? -LIM : y);
      e_dout = OUT_W'(y);
      m_ev++;
      e_valid = m_ev >= 4;
    end
    s3 += s2; s2 += s1; s1 += m_dsm ? 1 : -1;
    m_dsm = din;
    m_ph = (m_ph + 1) % R;
    n_cke++;
  endtask
  task automatic tick(input bit c, input bit din);
    cke = c; dsm_in = din;
    @(posedge clk); #1;
    if (c) model_cke(din); else e_valid = 0;
    cke = 0;
  endtask
  task automatic do_reset();
    cke = 0; rst = 1;
    @(negedge clk); rst = 0;
    model_reset();
  endtask
  task automatic test_reset();
    cke = 0; dsm_in = 0; rst = 1;
    #2;
    n_cmp += 3;
    if (dsm_out !== 1'b0) begin n_err++; $display("FAIL reset_dsm_out: got %b want 0", dsm_out); end
    if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", dout); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    @(negedge clk); rst = 0;
    model_reset();
  endtask
  task automatic test_const_one();
    int nv = 0;
    do_reset();
    for (int i = 0; i < 200*R; i++) begin
      for (int g = 0; g < 4; g++) begin
        tick(g == 0, 1'b1);
        if (i == 0 && g == 0) begin
          n_cmp++;
          if (dsm_out !== 1'b1) begin n_err++; $display("FAIL const1_dsm_out: got %b want 1", dsm_out); end
        end
        n_cmp++;
        if (dout_valid !== e_valid) begin n_err++; $display("FAIL const1_valid: got %b want %b ev=%0d", dout_valid, e_valid, m_ev); end
        if (dout_valid) begin
          nv++;
          n_cmp += 2;
          if (dout !== 10'sd511) begin n_err++; $display("FAIL const1_dout: got %0d want 511", dout); end
          if (dout !== e_dout) begin n_err++; $display("FAIL const1_model: got %0d want %0d", dout, e_dout); end
        end
      end
    end
    n_cmp++;
    if (nv !== 197) begin n_err++; $display("FAIL const1_count: got %0d want 197", nv); end
  endtask
  task automatic test_patterns();
    logic [3:0] pats [4] = '{4'b0000, 4'b0101, 4'b0111, 4'b1000};
    int exps [4] = '{-512, 0, 256, -256};
    for (int p = 0; p < 4; p++) begin
      int nv = 0;
      logic [3:0] pat = pats[p];
      do_reset();
      for (int i = 0; i < 12*R; i++) begin
        int gaps = $urandom_range(0, 2);
        for (int g = 0; g <= gaps; g++) begin
          tick(g == gaps, g == gaps ? pat[i%4] : 1'($urandom));
          n_cmp++;
          if (dout_valid !== e_valid) begin n_err++; $display("FAIL pat%0d_valid: got %b want %b", p, dout_valid, e_valid); end
          if (dout_valid) begin
            nv++;
            n_cmp += 2;
            if (dout !== OUT_W'(exps[p])) begin n_err++; $display("FAIL pat%0d_dout: got %0d want %0d", p, dout, exps[p]); end
            if (dout !== e_dout) begin n_err++; $display("FAIL pat%0d_model: got %0d want %0d", p, dout, e_dout); end
          end
        end
      end
      n_cmp++;
      if (nv !== 9) begin n_err++; $display("FAIL pat%0d_count: got %0d want 9", p, nv); end
    end
  endtask
  task automatic test_closed_loop();
    longint acc = 0;
    longint last = -1;
    bit prev_v = 0;
    do_reset();
    for (int i = 0; i < 1040*R; i++) begin
      bit din;
      acc += 200 - (m_dsm ? 512 : -512);
      din = acc >= 0;
      tick(1'b1, din);
      n_cmp += 3;
      if (dsm_out !== m_dsm) begin n_err++; $display("FAIL loop_dsm_out: got %b want %b", dsm_out, m_dsm); end
      if (dout_valid !== e_valid) begin n_err++; $display("FAIL loop_valid: got %b want %b", dout_valid, e_valid); end
      if (prev_v && dout_valid) begin n_err++; $display("FAIL loop_back_to_back: got 1 want 0"); end
      prev_v = dout_valid;
      if (dout_valid) begin
        n_cmp++;
        if (dout !== e_dout) begin n_err++; $display("FAIL loop_model: got %0d want %0d", dout, e_dout); end
        if (m_ev > 8) begin
          n_cmp++;
          if (dout < 198 || dout > 202) begin n_err++; $display("FAIL loop_range: got %0d want 198..202", dout); end
        end
        if (last >= 0) begin
          n_cmp++;
          if (n_cke - last !== R) begin n_err++; $display("FAIL loop_spacing: got %0d want %0d", n_cke - last, R); end
        end
        last = n_cke;
      end
    end
  endtask
  task automatic test_mid_reset();
    int first = 0;
    int changes = 0;
    logic signed [OUT_W-1:0] h_dout;
    logic h_dsm;
    do_reset();
    while (m_ev < 5 || m_ph != 16) tick(1'b1, $urandom_range(0, 3) != 0);
    tick(1'b1, 1'b1);
    #3 rst = 1;
    #2;
    n_cmp += 3;
    if (dsm_out !== 1'b0) begin n_err++; $display("FAIL midrst_dsm_out: got %b want 0", dsm_out); end
    if (dout !== '0) begin n_err++; $display("FAIL midrst_dout: got %0d want 0", dout); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", dout_valid); end
    @(negedge clk); rst = 0;
    model_reset();
    for (int i = 0; i < 5*R; i++) begin
      int gaps = $urandom_range(0, 1);
      for (int g = 0; g <= gaps; g++) begin
        tick(g == gaps, 1'($urandom));
        n_cmp++;
        if (dout_valid !== e_valid) begin n_err++; $display("FAIL midrst_valid_seq: got %b want %b", dout_valid, e_valid); end
        if (dout_valid && first == 0) first = m_ev;
      end
    end
    n_cmp++;
    if (first !== 4) begin n_err++; $display("FAIL midrst_first_event: got %0d want 4", first); end
    h_dout = dout; h_dsm = dsm_out;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'($urandom));
      if (dout !== h_dout || dsm_out !== h_dsm || dout_valid !== 1'b0) changes++;
    end
    n_cmp++;
    if (changes !== 0) begin n_err++; $display("FAIL hold_changes: got %0d want 0", changes); end
    for (int i = 0; i < 3*R; i++) begin
      tick(1'b1, 1'($urandom));
      n_cmp++;
      if (dout_valid !== e_valid) begin n_err++; $display("FAIL hold_valid: got %b want %b", dout_valid, e_valid); end
      if (dout_valid) begin
        n_cmp++;
        if (dout !== e_dout) begin n_err++; $display("FAIL hold_model: got %0d want %0d", dout, e_dout); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_const_one();
    test_patterns();
    test_closed_loop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
